// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Initiator side of the MIPS32SOC data-memory port. Accepts one load/store
// request at a time from the CPU pipeline and turns it into a single
// word-addressed, byte-masked access on a data memory with a one-cycle
// registered read. Handles big-endian lane formatting for stores, lane
// selection plus sign/zero extension for loads, and rejects illegal requests
// (out of range, size 2'b11) without touching memory.
//
// Optional feature macro: ALIGN_CHECK_EN
//   defined   : misaligned halfword/word requests are rejected with resp_err.
//   undefined : misaligned halfword/word addresses are aligned down.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_write             1 = store, 0 = load
//   req_size              00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned          load zero-extends when 1, sign-extends when 0
//   req_addr              byte address
//   req_wdata             right-justified store data
//   resp_valid            single-cycle completion pulse
//   resp_rdata            extended load data (0 for stores and errors)
//   resp_err              request rejected, no memory access made
//   mem_en                memory chip enable (one cycle per access)
//   mem_write             byte write mask, bit i = byte offset i (bit0 = [31:24])
//   mem_addr              memory word address
//   mem_wdata             lane-replicated write data
//   mem_rdata             memory read data, valid the cycle after mem_en
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int          ADDR_WORDS = 2048,
  parameter int          AW         = 11,
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          mem_en,
  output logic [3:0]    mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [31:0] SPAN_BYTES = 32'(4 * ADDR_WORDS);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  // Byte write mask for a store; lane is the (already aligned) byte offset.
  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b0001 << lane;
      SZ_HALF: mask = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Replicate right-justified store data across every lane it could occupy.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] data;
    case (size)
      SZ_BYTE: data = {4{wdata[7:0]}};
      SZ_HALF: data = {2{wdata[15:0]}};
      SZ_WORD: data = wdata;
      default: data = 32'h0000_0000;
    endcase
    return data;
  endfunction

  // Pick the addressed big-endian lane out of a memory word and extend it.
  function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                               input logic        zext,
                                               input logic [1:0]  lane,
                                               input logic [31:0] rdata);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] result;
    case (lane)
      2'd0:    byte_v = rdata[31:24];
      2'd1:    byte_v = rdata[23:16];
      2'd2:    byte_v = rdata[15:8];
      2'd3:    byte_v = rdata[7:0];
      default: byte_v = 8'h00;
    endcase
    half_v = lane[1] ? rdata[15:0] : rdata[31:16];
    case (size)
      SZ_BYTE: result = zext ? {24'h00_0000, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_HALF: result = zext ? {16'h0000, half_v} : {{16{half_v[15]}}, half_v};
      SZ_WORD: result = rdata;
      default: result = 32'h0000_0000;
    endcase
    return result;
  endfunction

  state_t          state_r;
  logic            write_r;
  logic [1:0]      size_r;
  logic            unsigned_r;
  logic [1:0]      lane_r;
  logic            resp_valid_r;
  logic [31:0]     resp_rdata_r;
  logic            resp_err_r;
  logic            mem_en_r;
  logic [3:0]      mem_write_r;
  logic [AW-1:0]   mem_addr_r;
  logic [31:0]     mem_wdata_r;

  logic [31:0]     off_s;
  logic [1:0]      lane_s;
  logic            range_err_s;
  logic            align_err_s;
  logic            req_err_s;
  logic            req_ready_s;
  logic            handshake_s;

  // Request decode: byte offset into the memory window, aligned lane, error flags.
  always_comb begin
    off_s       = req_addr - BASE_ADDR;
    range_err_s = (off_s >= SPAN_BYTES);
    lane_s      = off_s[1:0];
    align_err_s = 1'b0;
    case (req_size)
      SZ_BYTE: begin
        lane_s = off_s[1:0];
      end
      SZ_HALF: begin
        lane_s = {off_s[1], 1'b0};
`ifdef ALIGN_CHECK_EN
        align_err_s = off_s[0];
`endif
      end
      SZ_WORD: begin
        lane_s = 2'b00;
`ifdef ALIGN_CHECK_EN
        align_err_s = (off_s[1:0] != 2'b00);
`endif
      end
      default: begin
        lane_s = 2'b00;
      end
    endcase
    req_err_s = range_err_s || align_err_s || (req_size == SZ_BAD);
  end

  // Ready only in IDLE; gated by rst_n so it reads 0 for as long as reset is
  // held and 1 in the very first cycle after release.
  always_comb begin
    if (rst_n && (state_r == S_IDLE)) begin
      req_ready_s = 1'b1;
    end else begin
      req_ready_s = 1'b0;
    end
    handshake_s = req_valid && req_ready_s;
  end

  // Request FSM with all memory-side and response outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      write_r      <= 1'b0;
      size_r       <= 2'b00;
      unsigned_r   <= 1'b0;
      lane_r       <= 2'b00;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      resp_err_r   <= 1'b0;
      mem_en_r     <= 1'b0;
      mem_write_r  <= 4'b0000;
      mem_addr_r   <= '0;
      mem_wdata_r  <= 32'h0000_0000;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (handshake_s) begin
            if (req_err_s) begin
              // Rejected requests skip memory and respond in the next cycle.
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= 32'h0000_0000;
              state_r      <= S_RESP;
            end else begin
              write_r     <= req_write;
              size_r      <= req_size;
              unsigned_r  <= req_unsigned;
              lane_r      <= lane_s;
              mem_en_r    <= 1'b1;
              mem_addr_r  <= off_s[AW+1:2];
              mem_write_r <= req_write ? store_mask(req_size, lane_s) : 4'b0000;
              mem_wdata_r <= req_write ? store_data(req_size, req_wdata) : 32'h0000_0000;
              state_r     <= S_ACCESS;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ACCESS: begin
          mem_en_r    <= 1'b0;
          mem_write_r <= 4'b0000;
          if (write_r) begin
            // The write lands at the end of this cycle; the store is complete.
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            state_r      <= S_RESP;
          end else begin
            state_r <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          // Registered memory read data is valid in this cycle.
          resp_rdata_r <= load_extract(size_r, unsigned_r, lane_r, mem_rdata);
          resp_valid_r <= 1'b1;
          resp_err_r   <= 1'b0;
          state_r      <= S_RESP;
        end
        S_RESP: begin
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= 32'h0000_0000;
          state_r      <= S_IDLE;
        end
        default: begin
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= 32'h0000_0000;
          mem_en_r     <= 1'b0;
          mem_write_r  <= 4'b0000;
          state_r      <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_s;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;
  assign mem_en     = mem_en_r;
  assign mem_write  = mem_write_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the MIPS32SOC data-memory port: accepts one load/store request at a time from the CPU pipeline and translates it into word-addressed, byte-masked accesses on the data-memory interface. The data memory has a one-cycle registered read. This unit:
- formats big-endian byte/halfword lanes,
- sign- or zero-extends returned load data,
- flags illegal accesses.

It sits between the CPU execute/memory stage and the data memory.

## Interface
Parameters:
- ADDR_WORDS, 2048, memory depth in 32-bit words (power of two)
- AW, 11, memory word-address width, log2(ADDR_WORDS)
- BASE_ADDR, 32'h1001_0000, byte address mapped to memory word 0

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  unit can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  single-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  request rejected, no memory access made
- mem_en  out  1  memory chip enable
- mem_write  out  4  byte write mask; bit i = byte offset i (big-endian: bit0 → [31:24], bit3 → [7:0])
- mem_addr  out  AW  word address
- mem_wdata  out  32  lane-replicated write data
- mem_rdata  in  32  memory read data, valid the cycle after mem_en

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE:
  - req_ready=1.
  - A handshake occurs when req_valid&&req_ready.
  - On a handshake, compute off = req_addr - BASE_ADDR.
  - Error when off ≥ 4*ADDR_WORDS or req_size=11 → go to RESP with err=1.
  - Otherwise register mem_addr=off[AW+1:2] and the lane/mask values, then go to ACCESS.
- Stores:
  - Byte: mask = 1<<off[1:0]; data = {4{wdata[7:0]}}.
  - Halfword: off[1]=0 → mask 0011; off[1]=1 → mask 1100; data = {2{wdata[15:0]}}.
  - Word: mask 1111; data = wdata.
- Loads: mask 0000.
- ACCESS: mem_en=1 for exactly one cycle. Next state is RESP for a store, CAPTURE for a load.
- CAPTURE:
  - Select the lane from mem_rdata: byte offset k → bits [31-8k:24-8k]; halfword offset 0 → [31:16], offset 2 → [15:0].
  - Extend the lane per req_unsigned and register it into resp_rdata. Next state is RESP.
- RESP: resp_valid=1 for one cycle, then IDLE. There is no backpressure; the CPU must accept the pulse.
- mem_en, mem_write, mem_addr and mem_wdata are registered outputs. mem_write is 0 outside ACCESS.
- Only one request is in flight at a time. req_ready=0 in every state except IDLE.

## Timing
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE.
  - All outputs go to 0, including req_ready while reset is held.
  - req_ready=1 from the first cycle after release.
- The handshake cycle is T.
- Store: mem_en high in T+1; memory written at end of T+1; resp_valid in T+2.
- Load: mem_en in T+1; mem_rdata sampled in T+2; resp_valid/resp_rdata in T+3.
- Error: resp_valid with resp_err=1 in T+1; no mem_en.
- Reset asserted mid-operation aborts the request: no response is issued. A write already strobed in ACCESS stands.
- req_* inputs are sampled only at the handshake and may change afterwards.

## Configuration
- ALIGN_CHECK_EN defined:
  - A halfword with off[0]=1 or a word with off[1:0]≠0 is an error.
  - Error handling: resp_err=1 at T+1, no memory access.
- ALIGN_CHECK_EN undefined:
  - Misaligned addresses are silently aligned down: halfword clears off[0]; word clears off[1:0].
  - The access then proceeds normally.
- Range and size-11 checks are always present.

## Test plan
- Store word 0xDEADBEEF at 0x1001_0010 → T+1: mem_en=1, mem_addr=4, mem_write=1111, mem_wdata=0xDEADBEEF; T+2: resp_valid=1, err=0.
- Store byte 0xA5 at 0x1001_0013 → mem_write=1000, mem_wdata=0xA5A5A5A5; then signed byte load of the same address with memory word 0x000000A5 → resp_rdata=0xFFFFFFA5 at T+3.
- Unsigned halfword load at 0x1001_0002 with memory word 0x1234_8001 → resp_rdata=0x0000_8001; signed → 0xFFFF_8001.
- Load at 0x1001_2000 (out of range) and a req_size=11 request → resp_err=1 at T+1, resp_rdata=0, mem_en never asserted.
- Word load at 0x1001_0006:
  - With ALIGN_CHECK_EN → resp_err=1.
  - Without ALIGN_CHECK_EN → mem_addr=1, full word returned.
- rst_n=0 during the CAPTURE cycle of a load → no resp_valid; req_ready=1 in the first cycle after release; a following store completes normally.
